conv_addr_sequencer: RTL and testbench

Upstream address generator for the 4x4 pixel store. It drives the 4-bit address that the 4-to-16 row decoder turns into a one-hot row select. The block has two jobs: a LOAD pass that writes all 16 pixels in raster order, and a SCAN pass that issues read addresses for every valid 3x3 convolution window, tap by tap, to the MAC stage. Handshakes on both the pixel-in side and the MAC side let either neighbour stall it.

---
 rtl/conv_addr_sequencer_if.sv | 29 ++
 rtl/conv_addr_sequencer.sv | 169 ++++++++++++++++
 tb/tb_conv_addr_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_addr_sequencer_if.sv
// Handshake bundle between the conv address sequencer, its pixel source,
// the MAC stage and the 4-to-16 row decoder.
interface conv_addr_sequencer_if #(
  parameter int AW    = 4,
  parameter int WIN_W = 2
);
  logic             start_load;
  logic             start_conv;
  logic             pix_valid;
  logic             rd_ready;
  logic [AW-1:0]    addr;
  logic             wr_en;
  logic             rd_valid;
  logic             first_tap;
  logic             last_tap;
  logic [WIN_W-1:0] win_idx;
  logic             busy;
  logic             done;

  modport slave (
    input  start_load, start_conv, pix_valid, rd_ready,
    output addr, wr_en, rd_valid, first_tap, last_tap, win_idx, busy, done
  );

  modport master (
    output start_load, start_conv, pix_valid, rd_ready,
    input  addr, wr_en, rd_valid, first_tap, last_tap, win_idx, busy, done
  );
endinterface

// File: rtl/conv_addr_sequencer.sv
// Address sequencer for the pixel store: raster LOAD pass, then per-window,
// per-tap SCAN read addresses for a KxK convolution over an IMG_DIM image.
//
// state | meaning
// IDLE  | waiting for start_load / start_conv (LOAD wins a tie)
// LOAD  | writing pixels in raster order, one per pix_valid
// SCAN  | issuing tap addresses, advancing on rd_valid & rd_ready
// DONE  | one-cycle done pulse, then back to IDLE
module conv_addr_sequencer #(
  parameter int IMG_DIM = 4,
  parameter int K       = 3,
  parameter int AW      = 4
) (
  input  logic clk,
  input  logic rst,
  conv_addr_sequencer_if.slave bus
);

  localparam int NWIN  = IMG_DIM - K + 1;
  localparam int WIN_W = ((NWIN * NWIN) > 1) ? $clog2(NWIN * NWIN) : 1;

  localparam logic [AW-1:0] DIM_V  = AW'(IMG_DIM);
  localparam logic [AW-1:0] NWIN_V = AW'(NWIN);
  localparam logic [AW-1:0] WMAX   = AW'(IMG_DIM - K);
  localparam logic [AW-1:0] KMAX   = AW'(K - 1);
  localparam logic [AW-1:0] LAST_A = AW'(IMG_DIM * IMG_DIM - 1);
  localparam logic          K_ONE  = (K == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    wr_q, wc_q, kr_q, kc_q;
  logic [AW-1:0]    wr_d, wc_d, kr_d, kc_d;
  logic [AW-1:0]    scan_addr_d;
  logic [WIN_W-1:0] win_idx_q;
  logic             rd_valid_q, first_tap_q, last_tap_q, busy_q, done_q;
  logic             tap_last, win_last;

  // Next scan position: kc fastest, then kr, then wc, then wr.
  always_comb begin
    kc_d     = kc_q;
    kr_d     = kr_q;
    wc_d     = wc_q;
    wr_d     = wr_q;
    tap_last = (kr_q == KMAX) && (kc_q == KMAX);
    win_last = (wr_q == WMAX) && (wc_q == WMAX);
    if (kc_q != KMAX) begin
      kc_d = kc_q + AW'(1);
    end else begin
      kc_d = '0;
      if (kr_q != KMAX) begin
        kr_d = kr_q + AW'(1);
      end else begin
        kr_d = '0;
        if (wc_q != WMAX) begin
          wc_d = wc_q + AW'(1);
        end else begin
          wc_d = '0;
          wr_d = (wr_q != WMAX) ? wr_q + AW'(1) : '0;
        end
      end
    end
    scan_addr_d = (wr_d + kr_d) * DIM_V + (wc_d + kc_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= '0;
      wc_q        <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      win_idx_q   <= '0;
      rd_valid_q  <= 1'b0;
      first_tap_q <= 1'b0;
      last_tap_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_load) begin
            state_q <= LOAD;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end else if (bus.start_conv) begin
            state_q     <= SCAN;
            addr_q      <= '0;
            wr_q        <= '0;
            wc_q        <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            win_idx_q   <= '0;
            rd_valid_q  <= 1'b1;
            first_tap_q <= 1'b1;
            last_tap_q  <= K_ONE;
            busy_q      <= 1'b1;
          end
        end

        LOAD: begin
          if (bus.pix_valid) begin
            if (addr_q == LAST_A) begin
              state_q <= DONE;
              addr_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end

        SCAN: begin
          if (bus.rd_ready) begin
            if (tap_last && win_last) begin
              state_q     <= DONE;
              addr_q      <= '0;
              wr_q        <= '0;
              wc_q        <= '0;
              kr_q        <= '0;
              kc_q        <= '0;
              win_idx_q   <= '0;
              rd_valid_q  <= 1'b0;
              first_tap_q <= 1'b0;
              last_tap_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              wr_q        <= wr_d;
              wc_q        <= wc_d;
              kr_q        <= kr_d;
              kc_q        <= kc_d;
              addr_q      <= scan_addr_d;
              win_idx_q   <= WIN_W'(wr_d * NWIN_V + wc_d);
              first_tap_q <= (kr_d == '0) && (kc_d == '0);
              last_tap_q  <= (kr_d == KMAX) && (kc_d == KMAX);
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // wr_en follows pix_valid combinationally so a write lands in the same cycle.
  assign bus.wr_en     = (state_q == LOAD) && bus.pix_valid;
  assign bus.addr      = addr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.first_tap = first_tap_q;
  assign bus.last_tap  = last_tap_q;
  assign bus.win_idx   = win_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Directed bench for conv_addr_sequencer: reset, LOAD with gaps, SCAN order,
// backpressure, start arbitration, reset mid-scan and row-decoder hook-up.
module tb_conv_addr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  conv_addr_sequencer_if #(.AW(4), .WIN_W(2)) bus ();

  conv_addr_sequencer #(.IMG_DIM(4), .K(3), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] row_select;
  assign row_select = 16'h0001 << bus.addr;

  int scan_tab [36] = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                        1, 2, 3, 5, 6, 7, 9, 10, 11,
                        4, 5, 6, 8, 9, 10, 12, 13, 14,
                        5, 6, 7, 9, 10, 11, 13, 14, 15};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pix_valid = 1'b1;
    step(); step();
    chk("reset_addr", int'(bus.addr), 0);
    chk("reset_win_idx", int'(bus.win_idx), 0);
    chk("reset_wr_en", int'(bus.wr_en), 0);
    chk("reset_rd_valid", int'(bus.rd_valid), 0);
    chk("reset_first_tap", int'(bus.first_tap), 0);
    chk("reset_last_tap", int'(bus.last_tap), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    bus.pix_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  // Checks the current SCAN tap against table entry i.
  task automatic chk_tap(input int i);
    chk("scan_addr", int'(bus.addr), scan_tab[i]);
    chk("scan_win_idx", int'(bus.win_idx), i / 9);
    chk("scan_first_tap", int'(bus.first_tap), (i % 9 == 0) ? 1 : 0);
    chk("scan_last_tap", int'(bus.last_tap), (i % 9 == 8) ? 1 : 0);
    chk("scan_rd_valid", int'(bus.rd_valid), 1);
    chk("scan_done_low", int'(bus.done), 0);
  endtask

  task automatic test_load_gaps();
    int accepts = 0;
    int exp_addr = 0;
    int steps = 0;
    bit pv;
    bus.start_load = 1'b1;
    step();
    bus.start_load = 1'b0;
    while (accepts < 16 && steps < 60) begin
      pv = (steps % 3) != 1;
      bus.pix_valid = pv;
      #1;
      chk("load_wr_en", int'(bus.wr_en), int'(pv));
      chk("load_addr", int'(bus.addr), exp_addr);
      chk("load_busy", int'(bus.busy), 1);
      chk("load_done_low", int'(bus.done), 0);
      if (pv) begin
        accepts++;
        exp_addr++;
      end
      steps++;
      step();
    end
    chk("load_accepts", accepts, 16);
    bus.pix_valid = 1'b1;
    #1;
    chk("load_done_pulse", int'(bus.done), 1);
    chk("load_done_busy", int'(bus.busy), 1);
    chk("load_done_addr", int'(bus.addr), 0);
    chk("load_done_wr_en", int'(bus.wr_en), 0);
    step();
    chk("load_idle_done", int'(bus.done), 0);
    chk("load_idle_busy", int'(bus.busy), 0);
    chk("load_idle_wr_en", int'(bus.wr_en), 0);
    step();
    chk("load_no_wrap_addr", int'(bus.addr), 0);
    chk("load_no_wrap_busy", int'(bus.busy), 0);
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_scan_free();
    bus.rd_ready = 1'b1;
    bus.start_conv = 1'b1;
    step();
    bus.start_conv = 1'b0;
    chk("scan_busy", int'(bus.busy), 1);
    for (int i = 0; i < 36; i++) begin
      chk_tap(i);
      step();
    end
    chk("scan_done_cycle37", int'(bus.done), 1);
    chk("scan_done_busy", int'(bus.busy), 1);
    chk("scan_done_rd_valid", int'(bus.rd_valid), 0);
    step();
    chk("scan_idle_done", int'(bus.done), 0);
    chk("scan_idle_busy", int'(bus.busy), 0);
  endtask

  task automatic test_scan_backpressure();
    int accepts = 0;
    bus.rd_ready = 1'b1;
    bus.start_conv = 1'b1;
    step();
    bus.start_conv = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (i == 13) begin
        chk("bp_stall_entry_addr", int'(bus.addr), 6);
        bus.rd_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("bp_hold_addr", int'(bus.addr), 6);
          chk("bp_hold_win_idx", int'(bus.win_idx), 1);
          chk("bp_hold_first_tap", int'(bus.first_tap), 0);
          chk("bp_hold_last_tap", int'(bus.last_tap), 0);
          chk("bp_hold_rd_valid", int'(bus.rd_valid), 1);
        end
        bus.rd_ready = 1'b1;
      end
      chk_tap(i);
      if (bus.rd_valid && bus.rd_ready) accepts++;
      step();
      if (i == 13) chk("bp_resume_addr", int'(bus.addr), 7);
    end
    chk("bp_accepts", accepts, 36);
    chk("bp_done", int'(bus.done), 1);
    step();
    chk("bp_idle_busy", int'(bus.busy), 0);
  endtask

  task automatic test_start_arbitration();
    bus.start_load = 1'b1;
    bus.start_conv = 1'b1;
    step();
    bus.start_load = 1'b0;
    bus.start_conv = 1'b0;
    chk("arb_busy", int'(bus.busy), 1);
    chk("arb_rd_valid", int'(bus.rd_valid), 0);
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.start_conv = (i == 3);
      #1;
      chk("arb_load_wr_en", int'(bus.wr_en), 1);
      chk("arb_load_addr", int'(bus.addr), i);
      chk("arb_load_rd_valid", int'(bus.rd_valid), 0);
      step();
    end
    bus.pix_valid = 1'b0;
    bus.start_conv = 1'b1;
    chk("arb_done", int'(bus.done), 1);
    step();
    bus.start_conv = 1'b0;
    chk("arb_idle_busy", int'(bus.busy), 0);
    chk("arb_idle_rd_valid", int'(bus.rd_valid), 0);
    step();
    chk("arb_not_queued_busy", int'(bus.busy), 0);
    chk("arb_not_queued_rd_valid", int'(bus.rd_valid), 0);
  endtask

  task automatic test_reset_mid_scan();
    bus.rd_ready = 1'b1;
    bus.start_conv = 1'b1;
    step();
    bus.start_conv = 1'b0;
    for (int i = 0; i < 23; i++) step();
    chk("rst_mid_pre_addr", int'(bus.addr), 10);
    chk("rst_mid_pre_win", int'(bus.win_idx), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_addr", int'(bus.addr), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_mid_done", int'(bus.done), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_mid_no_done", int'(bus.done), 0);
      chk("rst_mid_stay_idle", int'(bus.busy), 0);
    end
    bus.start_conv = 1'b1;
    step();
    bus.start_conv = 1'b0;
    chk("rst_mid_restart_addr", int'(bus.addr), 0);
    chk("rst_mid_restart_first", int'(bus.first_tap), 1);
    chk("rst_mid_restart_rd_valid", int'(bus.rd_valid), 1);
    for (int i = 0; i < 37; i++) step();
    chk("rst_mid_restart_end_busy", int'(bus.busy), 0);
  endtask

  task automatic test_decoder();
    logic [15:0] exp_row;
    bus.rd_ready = 1'b1;
    bus.start_conv = 1'b1;
    step();
    bus.start_conv = 1'b0;
    for (int i = 0; i < 36; i++) begin
      exp_row = 16'h0001 << scan_tab[i];
      chk("dec_onehot", int'($onehot(row_select)), 1);
      chk("dec_row_select", int'(row_select), int'(exp_row));
      step();
    end
    step();
    chk("dec_end_busy", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start_load = 1'b0;
    bus.start_conv = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.rd_ready   = 1'b0;
    test_reset();
    test_load_gaps();
    test_scan_free();
    test_scan_backpressure();
    test_start_arbitration();
    test_reset_mid_scan();
    test_decoder();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
